// File: rtl/token_burst_gen.sv
// -----------------------------------------------------------------------------
// token_burst_gen
//
// Upstream token source for the token-stream stages. The block accepts burst
// commands over a valid/ready handshake and, for each one, emits cmd_len
// single-cycle tokens on tok. cmd_gap idle cycles separate consecutive tokens.
// A downstream hold input stalls emission and freezes every counter. A
// running tok_total counts the tokens emitted since reset and wraps silently.
//
// Ports
//   clk        in   1      clock
//   rst        in   1      synchronous, active-high reset
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      block can accept a command this cycle
//   cmd_len    in   LEN_W  number of tokens in the burst (0 = empty command)
//   cmd_gap    in   GAP_W  idle cycles between consecutive tokens
//   hold       in   1      downstream stall: no token, all counters frozen
//   tok        out  1      token output, one cycle high per token
//   busy       out  1      a burst is in progress (EMIT or GAP)
//   done       out  1      one-cycle pulse the cycle after a command completes
//   tok_total  out  CNT_W  tokens emitted since reset, modulo 2^CNT_W
// -----------------------------------------------------------------------------
module token_burst_gen #(
    parameter int LEN_W = 8,
    parameter int GAP_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [GAP_W-1:0] cmd_gap,
    input  logic             hold,
    output logic             tok,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] tok_total
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    state_e             state_q,      state_d;
    logic [LEN_W-1:0]   remaining_q,  remaining_d;   // tokens still to emit, current one included
    logic [GAP_W-1:0]   gap_reload_q, gap_reload_d;  // latched cmd_gap for the whole burst
    logic [GAP_W-1:0]   gap_cnt_q,    gap_cnt_d;     // idle cycles left before the next token
    logic               done_q,       done_d;
    logic [CNT_W-1:0]   tok_total_q,  tok_total_d;

    logic               accept;

    // -------------------------------------------------------------------------
    // Combinational outputs, all decoded straight from the state register.
    // cmd_ready is forced low during reset so no command can slip in while
    // the block is being cleared.
    // -------------------------------------------------------------------------
    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign tok       = (state_q == S_EMIT) && !hold;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign tok_total = tok_total_q;

    // -------------------------------------------------------------------------
    // Next-state logic.
    // The counters use "reaches 1" as the terminal condition and never
    // pre-decrement on load. The full field ranges (2^LEN_W-1 tokens,
    // 2^GAP_W-1 gap cycles) therefore fit without an extra counter bit.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves it unassigned; a missed branch would otherwise infer a latch.
        state_d      = state_q;
        remaining_d  = remaining_q;
        gap_reload_d = gap_reload_q;
        gap_cnt_d    = gap_cnt_q;
        done_d       = 1'b0;
        tok_total_d  = tok_total_q;

        if (tok) begin
            // Wraps modulo 2^CNT_W by design.
            tok_total_d = tok_total_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_len == '0) begin
                        // Empty command: complete immediately and stay ready.
                        done_d = 1'b1;
                    end else begin
                        state_d      = S_EMIT;
                        remaining_d  = cmd_len;
                        gap_reload_d = cmd_gap;
                    end
                end
            end

            S_EMIT: begin
                if (!hold) begin
                    if (remaining_q == LEN_W'(1)) begin
                        // Last token goes out this cycle; done follows next cycle
                        // with the block already back in IDLE and ready.
                        state_d     = S_IDLE;
                        remaining_d = '0;
                        done_d      = 1'b1;
                    end else begin
                        remaining_d = remaining_q - LEN_W'(1);
                        if (gap_reload_q != '0) begin
                            state_d   = S_GAP;
                            gap_cnt_d = gap_reload_q;
                        end
                    end
                end
            end

            S_GAP: begin
                if (!hold) begin
                    if (gap_cnt_q == GAP_W'(1)) begin
                        state_d   = S_EMIT;
                        gap_cnt_d = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q - GAP_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register. Reset is synchronous and takes priority over cmd_valid
    // and hold. An in-flight burst is dropped without a done pulse.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples its pre-edge value regardless of statement order.
        if (rst) begin
            state_q      <= S_IDLE;
            remaining_q  <= '0;
            gap_reload_q <= '0;
            gap_cnt_q    <= '0;
            done_q       <= 1'b0;
            tok_total_q  <= '0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            gap_reload_q <= gap_reload_d;
            gap_cnt_q    <= gap_cnt_d;
            done_q       <= done_d;
            tok_total_q  <= tok_total_d;
        end
    end

endmodule

// File: tb/tb_token_burst_gen.sv
// -----------------------------------------------------------------------------
// tb_token_burst_gen
//
// Directed bench for token_burst_gen. A second instance with CNT_W=4 shares
// every input with the main instance so that counter wrap can be observed.
// Inputs change on the falling edge. Outputs are sampled 1 ns later, well
// away from the rising edge.
// -----------------------------------------------------------------------------
module tb_token_burst_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_len;
    logic [3:0]  cmd_gap;
    logic        hold;
    logic        tok;
    logic        busy;
    logic        done;
    logic [15:0] tok_total;

    logic        cmd_ready4;
    logic        tok4;
    logic        busy4;
    logic        done4;
    logic [3:0]  tok_total4;

    int n_pass  = 0;
    int n_total = 0;
    int exp_total = 0;

    always #5 clk = ~clk;

    token_burst_gen #(.LEN_W(8), .GAP_W(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .cmd_gap   (cmd_gap),
        .hold      (hold),
        .tok       (tok),
        .busy      (busy),
        .done      (done),
        .tok_total (tok_total)
    );

    token_burst_gen #(.LEN_W(8), .GAP_W(4), .CNT_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready4),
        .cmd_len   (cmd_len),
        .cmd_gap   (cmd_gap),
        .hold      (hold),
        .tok       (tok4),
        .busy      (busy4),
        .done      (done4),
        .tok_total (tok_total4)
    );

    // Cycle 0 presents the command. Cycles 1..ncyc-1 check {tok,busy,done,cmd_ready}
    // against the hand-written bit vectors. The command inputs are scrambled
    // after cycle 0 to show that only the latched values matter.
    task automatic run_vec(input string name, input logic [7:0] len, input logic [3:0] gap,
                           input logic [31:0] hold_v, input logic [31:0] tok_v,
                           input logic [31:0] busy_v, input logic [31:0] done_v,
                           input int ncyc);
        logic [3:0] obs;
        logic [3:0] exp;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            cmd_valid = (c == 0);
            cmd_len   = (c == 0) ? len : ~len;
            cmd_gap   = (c == 0) ? gap : ~gap;
            hold      = hold_v[c];
            #1;
            obs = {tok, busy, done, cmd_ready};
            exp = {tok_v[c], busy_v[c], done_v[c], ~busy_v[c]};
            n_total++;
            if (obs !== exp)
                $display("FAIL %s cycle %0d {tok,busy,done,ready}: got %b expected %b", name, c, obs, exp);
            else
                n_pass++;
            if (tok_v[c]) exp_total++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        hold      = 1'b0;
        #1;
        n_total++;
        if (tok_total !== 16'(exp_total))
            $display("FAIL %s tok_total: got %0d expected %0d", name, tok_total, exp_total);
        else
            n_pass++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; cmd_valid = 1'b0; hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_total = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; cmd_valid = 1'b1; cmd_len = 8'd5; cmd_gap = 4'd0; hold = 1'b1;
        #1;
        n_total++;
        if (cmd_ready !== 1'b0) $display("FAIL reset_ready_in_rst: got %b expected 0", cmd_ready);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0; cmd_valid = 1'b0; hold = 1'b0;
        #1;
        n_total++;
        if ({tok, busy, done, cmd_ready} !== 4'b0001)
            $display("FAIL reset_outputs {tok,busy,done,ready}: got %b expected 0001", {tok, busy, done, cmd_ready});
        else n_pass++;
        n_total++;
        if (tok_total !== 16'd0) $display("FAIL reset_total: got %0d expected 0", tok_total);
        else n_pass++;
        exp_total = 0;
    endtask

    task automatic test_zero_len();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = 8'd0; cmd_gap = 4'd5; hold = 1'b0;
        #1;
        n_total++;
        if (cmd_ready !== 1'b1) $display("FAIL zero_len_ready0: got %b expected 1", cmd_ready);
        else n_pass++;
        // Done cycle: issue len=1 back-to-back.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = 8'd1; cmd_gap = 4'd3;
        #1;
        n_total++;
        if ({tok, busy, done, cmd_ready} !== 4'b0011)
            $display("FAIL zero_len_done {tok,busy,done,ready}: got %b expected 0011", {tok, busy, done, cmd_ready});
        else n_pass++;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_len = 8'd0;
        #1;
        n_total++;
        if ({tok, busy, done, cmd_ready} !== 4'b1100)
            $display("FAIL b2b_token {tok,busy,done,ready}: got %b expected 1100", {tok, busy, done, cmd_ready});
        else n_pass++;
        exp_total++;
        @(negedge clk);
        #1;
        n_total++;
        if ({tok, busy, done, cmd_ready} !== 4'b0011)
            $display("FAIL b2b_done {tok,busy,done,ready}: got %b expected 0011", {tok, busy, done, cmd_ready});
        else n_pass++;
        n_total++;
        if (tok_total !== 16'(exp_total))
            $display("FAIL zero_len_total: got %0d expected %0d", tok_total, exp_total);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        int toks;
        int bad;
        toks = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = 8'd200; cmd_gap = 4'd0; hold = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            #1;
            if (tok === 1'b1) toks++;
        end
        n_total++;
        if (toks != 50) $display("FAIL mid_tokens_before_rst: got %0d expected 50", toks);
        else n_pass++;
        // Reset collides with a new command and hold; reset must win.
        @(negedge clk);
        rst = 1'b1; cmd_valid = 1'b1; cmd_len = 8'd5; hold = 1'b1;
        #1;
        n_total++;
        if (cmd_ready !== 1'b0) $display("FAIL mid_ready_in_rst: got %b expected 0", cmd_ready);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0; cmd_valid = 1'b0; hold = 1'b0;
        #1;
        exp_total = 0;
        n_total++;
        if ({tok, busy, done, cmd_ready} !== 4'b0001)
            $display("FAIL mid_after_rst {tok,busy,done,ready}: got %b expected 0001", {tok, busy, done, cmd_ready});
        else n_pass++;
        n_total++;
        if (tok_total !== 16'd0) $display("FAIL mid_total: got %0d expected 0", tok_total);
        else n_pass++;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0 || tok !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL mid_quiet_after_rst: got %0d active cycles expected 0", bad);
        else n_pass++;
        run_vec("post_rst_len4_gap0", 8'd4, 4'd0, 32'h0, 32'h1E, 32'h1E, 32'h20, 6);
    endtask

    task automatic test_wrap();
        apply_reset();
        run_vec("wrap_len10_gap0", 8'd10, 4'd0, 32'h0, 32'h7FE, 32'h7FE, 32'h800, 12);
        run_vec("wrap_len8_gap1", 8'd8, 4'd1, 32'h0, 32'hAAAA, 32'hFFFE, 32'h10000, 17);
        n_total++;
        if (tok_total4 !== 4'd2) $display("FAIL wrap_cnt4: got %0d expected 2", tok_total4);
        else n_pass++;
    endtask

    task automatic test_max_burst();
        int  toks, busy_cyc, run, bad_gaps;
        bit  seen_done;
        toks = 0; busy_cyc = 0; run = 0; bad_gaps = 0; seen_done = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = 8'd255; cmd_gap = 4'd15; hold = 1'b0;
        #1;
        for (int c = 1; c < 5000 && !seen_done; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            #1;
            if (busy === 1'b1) busy_cyc++;
            if (done === 1'b1) seen_done = 1;
            if (tok === 1'b1) begin
                if (toks > 0 && run != 15) bad_gaps++;
                toks++;
                run = 0;
            end else begin
                run++;
            end
        end
        exp_total += 255;
        n_total++;
        if (!seen_done) $display("FAIL max_done_timeout: got no done expected done within 5000 cycles");
        else n_pass++;
        n_total++;
        if (toks != 255) $display("FAIL max_tokens: got %0d expected 255", toks);
        else n_pass++;
        n_total++;
        if (bad_gaps != 0) $display("FAIL max_gaps: got %0d wrong gaps expected 0", bad_gaps);
        else n_pass++;
        n_total++;
        if (busy_cyc != 4065) $display("FAIL max_busy_cycles: got %0d expected 4065", busy_cyc);
        else n_pass++;
        n_total++;
        if (tok_total !== 16'(exp_total))
            $display("FAIL max_total: got %0d expected %0d", tok_total, exp_total);
        else n_pass++;
        n_total++;
        if (tok_total4 !== 4'(exp_total))
            $display("FAIL max_total4: got %0d expected %0d", tok_total4, exp_total % 16);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_gap = '0; hold = 1'b0;
        test_reset();
        run_vec("len4_gap0", 8'd4, 4'd0, 32'h0, 32'h1E, 32'h1E, 32'h20, 6);
        run_vec("len3_gap2", 8'd3, 4'd2, 32'h0, 32'h92, 32'hFE, 32'h100, 9);
        run_vec("len3_gap2_hold", 8'd3, 4'd2, 32'h14, 32'h242, 32'h3FE, 32'h400, 11);
        test_zero_len();
        test_reset_mid_burst();
        test_wrap();
        test_max_burst();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
